axis_averager_fifo: RTL and testbench

//  FIFO responder for the native FIFO_WRITE/FIFO_READ ports of the averager: accepts wren/data, serves rden/data.

---
 rtl/axis_averager_fifo_pkg.sv | 17 +
 rtl/axis_averager_fifo_sdp_bram.sv | 30 +++
 rtl/axis_averager_fifo.sv | 144 ++++++++++++++
 tb/tb_axis_averager_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_averager_fifo_pkg.sv
// Shared definitions for the averager frame FIFO.
//   fifo_depth()        : RAM depth for a given address width
//   STAT_*_BIT          : positions of the sticky flags in the status register
//   PF_*                : prefetch FSM state encodings
package axis_averager_fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int STAT_OVERFLOW_BIT  = 0;
  localparam int STAT_UNDERFLOW_BIT = 1;

  localparam logic [0:0] PF_IDLE  = 1'b0;
  localparam logic [0:0] PF_FETCH = 1'b1;

endpackage

// File: rtl/axis_averager_fifo_sdp_bram.sv
// Simple dual-port block RAM, DATA_WIDTH x 2**ADDR_WIDTH.
// Ports: aclk; write port (wr_en, wr_addr, wr_data), synchronous write;
//        read port (rd_en, rd_addr) with registered rd_data, 1-cycle latency.
// A read of the address being written returns the old contents.
module axis_averager_fifo_sdp_bram
  import axis_averager_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset: keeps the array mappable onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_averager_fifo.sv
// First-word-fall-through FIFO between the averager write and read ports.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   fifo_write_full/data/wren write side; writes dropped while full
//   fifo_read_empty/data/rden read side; data valid whenever empty=0
//   fill_count               words held (RAM + read in flight + output stage)
//   overflow, underflow      sticky error flags, cleared by reset only
//
// Prefetch FSM (state register records the decision taken last cycle):
//   state    | meaning
//   PF_IDLE  | no RAM read in flight
//   PF_FETCH | a RAM read was issued last cycle; its word is on ram_dout now
module axis_averager_fifo
  import axis_averager_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  output logic                  fifo_write_full,
  input  logic [DATA_WIDTH-1:0] fifo_write_data,
  input  logic                  fifo_write_wren,
  output logic                  fifo_read_empty,
  output logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_read_rden,
  output logic [ADDR_WIDTH+1:0] fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH+1:0] FILL_ONE = (ADDR_WIDTH+2)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic [ADDR_WIDTH:0]   ram_count_next;
  logic                  full_q;
  logic [0:0]            pf_state;
  logic [1:0]            out_count;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [ADDR_WIDTH+1:0] fill_q;
  logic [1:0]            sticky;

  logic       wr_acc;
  logic       pop;
  logic       inflight;
  logic       fetch;
  logic [2:0] stage_after;

  assign wr_acc   = fifo_write_wren & ~full_q;
  assign pop      = fifo_read_rden & (out_count != 2'd0);
  assign inflight = (pf_state == PF_FETCH);

  // Output-stage slots that will be spoken for after this cycle's pop and
  // landing; a new read is only issued if it is guaranteed a free slot.
  assign stage_after = {1'b0, out_count} + {2'b00, inflight} - {2'b00, pop};
  assign fetch       = (ram_count != '0) && (stage_after < 3'd2);

  assign ram_count_next = ram_count + (ADDR_WIDTH+1)'(wr_acc)
                                    - (ADDR_WIDTH+1)'(fetch);

  axis_averager_fifo_sdp_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (fifo_write_data),
    .rd_en   (fetch),
    .rd_addr (rd_ptr),
    .rd_data (ram_dout)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      full_q    <= 1'b0;
      pf_state  <= PF_IDLE;
      out_count <= 2'd0;
      head_q    <= '0;
      skid_q    <= '0;
      fill_q    <= '0;
      sticky    <= 2'b00;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (fetch)  rd_ptr <= rd_ptr + PTR_ONE;
      ram_count <= ram_count_next;
      // A pop this cycle drains the output stage, not the RAM, so it never
      // clears full on its own.
      full_q    <= (ram_count_next == DEPTH_CNT);
      pf_state  <= fetch ? PF_FETCH : PF_IDLE;

      // The fetch rule guarantees a landing word never meets a full stage
      // without a pop, so the skid reg is never overwritten while live.
      case ({pop, inflight})
        2'b01: begin
          if (out_count == 2'd0) head_q <= ram_dout;
          else                   skid_q <= ram_dout;
        end
        2'b10: begin
          if (out_count == 2'd2) head_q <= skid_q;
        end
        2'b11: begin
          if (out_count == 2'd2) begin
            head_q <= skid_q;
            skid_q <= ram_dout;
          end else begin
            head_q <= ram_dout;
          end
        end
        default: ;
      endcase
      out_count <= out_count + {1'b0, inflight} - {1'b0, pop};

      case ({wr_acc, pop})
        2'b10:   fill_q <= fill_q + FILL_ONE;
        2'b01:   fill_q <= fill_q - FILL_ONE;
        default: ;
      endcase

      if (fifo_write_wren && full_q)
        sticky[STAT_OVERFLOW_BIT] <= 1'b1;
      if (fifo_read_rden && (out_count == 2'd0))
        sticky[STAT_UNDERFLOW_BIT] <= 1'b1;
    end
  end

  assign fifo_write_full = full_q;
  assign fifo_read_empty = (out_count == 2'd0);
  assign fifo_read_data  = head_q;
  assign fill_count      = fill_q;
  assign overflow        = sticky[STAT_OVERFLOW_BIT];
  assign underflow       = sticky[STAT_UNDERFLOW_BIT];

endmodule

// File: tb/tb_axis_averager_fifo.sv
// Self-checking bench for axis_averager_fifo (ADDR_WIDTH=4, D=16).
// A queue model tracks accepted words, the edge at which each becomes
// visible, and the sticky flags; it is compared against the DUT on every
// falling edge. Directed sequences add literal expectations.
module tb_axis_averager_fifo;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int D   = 16;
  localparam int CAP = D + 2;

  logic          aclk;
  logic          aresetn;
  logic          full;
  logic [DW-1:0] wdata;
  logic          wren;
  logic          empty;
  logic [DW-1:0] rdata;
  logic          rden;
  logic [AW+1:0] fill;
  logic          ovf;
  logic          udf;

  axis_averager_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .fifo_write_full (full),
    .fifo_write_data (wdata),
    .fifo_write_wren (wren),
    .fifo_read_empty (empty),
    .fifo_read_data  (rdata),
    .fifo_read_rden  (rden),
    .fill_count      (fill),
    .overflow        (ovf),
    .underflow       (udf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            avail;   // first edge after which the word is at the head
  } ent_t;

  ent_t mq[$];
  int   now = 0;
  bit   m_ovf = 0;
  bit   m_udf = 0;
  bit   started = 0;

  function automatic bit model_empty();
    return (mq.size() == 0) || (mq[0].avail > now);
  endfunction

  always @(posedge aclk) begin
    bit   e_full;
    bit   e_empty;
    ent_t ne;
    e_full  = (mq.size() == CAP);
    e_empty = model_empty();
    if (!aresetn) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (wren && e_full) m_ovf = 1;
      if (rden && e_empty) m_udf = 1;
      if (rden && !e_empty) void'(mq.pop_front());
      if (wren && !e_full) begin
        ne.d     = wdata;
        ne.avail = now + 1 + 2;
        mq.push_back(ne);
      end
    end
    now     = now + 1;
    started = 1;
  end

  always @(negedge aclk) begin
    if (started) begin
      chk("cyc_empty", {63'd0, empty}, {63'd0, model_empty()});
      chk("cyc_full", {63'd0, full}, {63'd0, (mq.size() == CAP)});
      chk("cyc_fill", 64'(fill), 64'(mq.size()));
      chk("cyc_overflow", {63'd0, ovf}, {63'd0, m_ovf});
      chk("cyc_underflow", {63'd0, udf}, {63'd0, m_udf});
      if (!model_empty()) chk("cyc_data", 64'(rdata), 64'(mq[0].d));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_nonempty(input string nm);
    int t;
    t = 0;
    while (empty && t < 10) begin
      tick();
      t++;
    end
    chk(nm, {63'd0, empty}, 64'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (fill != 0 && t < 40) begin
      rden = ~empty;
      tick();
      t++;
    end
    rden = 1'b0;
    chk("drain_done", 64'(fill), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    wren    = 1'b0;
    rden    = 1'b0;
    wdata   = '0;
    repeat (3) tick();
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_udf", {63'd0, udf}, 64'd0);
    chk("rst_data", 64'(rdata), 64'd0);
    aresetn = 1'b1;
    tick();

    // single word latency
    wdata = 32'hA5; wren = 1'b1;
    tick();
    wren = 1'b0;
    chk("single_n_empty", {63'd0, empty}, 64'd1);
    tick();
    chk("single_n1_empty", {63'd0, empty}, 64'd1);
    tick();
    chk("single_n2_empty", {63'd0, empty}, 64'd0);
    chk("single_n2_data", 64'(rdata), 64'hA5);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("single_pop_empty", {63'd0, empty}, 64'd1);
    chk("single_pop_fill", 64'(fill), 64'd0);

    // fill to capacity, overflow, then drain in order
    for (int i = 1; i <= 18; i++) begin
      wdata = 32'(i); wren = 1'b1;
      tick();
    end
    wren = 1'b0;
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_count18", 64'(fill), 64'd18);
    chk("fill_no_ovf", {63'd0, ovf}, 64'd0);
    wdata = 32'd19; wren = 1'b1;
    tick();
    wren = 1'b0;
    chk("fill_ovf", {63'd0, ovf}, 64'd1);
    chk("fill_count_drop", 64'(fill), 64'd18);
    for (int i = 1; i <= 18; i++) begin
      wait_nonempty("fill_pop_ready");
      chk("fill_pop_data", 64'(rdata), 64'(i));
      rden = 1'b1;
      tick();
      rden = 1'b0;
    end
    chk("fill_drained_empty", {63'd0, empty}, 64'd1);
    chk("fill_drained_count", 64'(fill), 64'd0);

    // streaming: 2-word prime, then write every cycle with reads one behind
    wdata = 32'd100; wren = 1'b1;
    tick();
    wdata = 32'd101;
    tick();
    wren = 1'b0;
    repeat (4) tick();
    chk("prime_fill", 64'(fill), 64'd2);
    for (int k = 0; k < 1000; k++) begin
      wdata = 32'(1000 + k); wren = 1'b1; rden = (k >= 1);
      tick();
      chk("stream_fill", 64'(fill), 64'd3);
      chk("stream_nonempty", {63'd0, empty}, 64'd0);
    end
    wren = 1'b0;
    drain();
    chk("stream_no_udf", {63'd0, udf}, 64'd0);

    // underflow is sticky through later traffic
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("udf_set", {63'd0, udf}, 64'd1);
    chk("udf_fill", 64'(fill), 64'd0);
    for (int i = 0; i < 3; i++) begin
      wdata = 32'(32'h300 + i); wren = 1'b1;
      tick();
    end
    wren = 1'b0;
    wait_nonempty("udf_traffic_ready");
    chk("udf_traffic_head", 64'(rdata), 64'h300);
    drain();
    chk("udf_sticky", {63'd0, udf}, 64'd1);

    // reset mid-stream with a read in flight
    for (int i = 0; i < 10; i++) begin
      wdata = 32'(200 + i); wren = 1'b1;
      tick();
    end
    wren = 1'b0;
    chk("mid_fill10", 64'(fill), 64'd10);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("mid_rst_empty", {63'd0, empty}, 64'd1);
    chk("mid_rst_fill", 64'(fill), 64'd0);
    chk("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    chk("mid_rst_udf", {63'd0, udf}, 64'd0);
    repeat (3) tick();
    chk("mid_rst_still_empty", {63'd0, empty}, 64'd1);
    wdata = 32'h77; wren = 1'b1;
    tick();
    wren = 1'b0;
    wait_nonempty("mid_next_ready");
    chk("mid_next_data", 64'(rdata), 64'h77);
    chk("mid_next_fill", 64'(fill), 64'd1);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("mid_final_empty", {63'd0, empty}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
